// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite slave-side bus bundle for ahb_mem_slave.
// The master drives the address/control/write data; the slave returns ready, response and read data.
interface ahb_mem_slave_if #(
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int AHB_DATA_WIDTH    = 64
);
    logic                         HSEL;
    logic [AHB_ADDRESS_WIDTH-1:0] HADDR;
    logic [1:0]                   HTRANS;
    logic                         HWRITE;
    logic [2:0]                   HSIZE;
    logic [AHB_DATA_WIDTH-1:0]    HWDATA;
    logic                         HREADY;
    logic                         HRESP;
    logic [AHB_DATA_WIDTH-1:0]    HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte-addressable RAM with programmable wait states,
// two-cycle ERROR response for illegal transfers and a committed-write byte counter.
module ahb_mem_slave #(
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int MEM_BYTES         = 4096,
    parameter int WAIT_STATES       = 0
) (
    input  logic           clk,
    input  logic           rst,
    ahb_mem_slave_if.slave bus,
    output logic [31:0]    bytes_written
);
    localparam int AW  = AHB_ADDRESS_WIDTH;
    localparam int NB  = AHB_DATA_WIDTH / 8;
    localparam int LB  = $clog2(NB);
    localparam int MAW = $clog2(MEM_BYTES);
    localparam logic [AW:0] ONE       = (AW+1)'(1);
    localparam logic [AW:0] MEM_LIMIT = (AW+1)'(MEM_BYTES);

    typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                wcnt_q;
    logic [MAW-1:0]            addr_q;
    logic [2:0]                size_q;
    logic                      write_q;
    logic                      hready, hresp;
    logic [AHB_DATA_WIDTH-1:0] rdata;
    logic                      accept, illegal;
    logic [AW:0]               req_bytes, req_end;
    logic [NB-1:0]             lane_mask;
    logic [MAW-1:0]            base_addr;
    logic [31:0]               xfer_bytes;
    logic [7:0]                mem [MEM_BYTES] = '{default: 8'h00};

    assign accept = hready && bus.HSEL && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);

    // Address-phase legality; the extra address bit keeps the end-of-transfer sum from wrapping.
    always_comb begin
        req_bytes = ONE << bus.HSIZE;
        req_end   = {1'b0, bus.HADDR} + req_bytes;
        illegal   = (int'(bus.HSIZE) > LB)
                 || ((bus.HADDR & AW'(req_bytes - ONE)) != '0)
                 || (req_end > MEM_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.HADDR[MAW-1:0];
                size_q  <= bus.HSIZE;
                write_q <= bus.HWRITE;
            end
            if (accept && !illegal && WAIT_STATES > 0)
                wcnt_q <= 4'(WAIT_STATES - 1);
            else if (state_q == WAIT && wcnt_q != '0)
                wcnt_q <= wcnt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    if (wcnt_q == '0) state_d = LAST;
            ERR1:    state_d = ERR2;
            default: begin
                if (accept)
                    state_d = illegal ? ERR1 : ((WAIT_STATES > 0) ? WAIT : LAST);
                else
                    state_d = IDLE;
            end
        endcase
    end

    // Active byte lanes of the registered transfer within the data bus.
    always_comb begin
        xfer_bytes = 32'd1 << size_q;
        base_addr  = {addr_q[MAW-1:LB], {LB{1'b0}}};
        lane_mask  = '0;
        for (int unsigned i = 0; i < NB; i++)
            lane_mask[i] = (i >= 32'(addr_q[LB-1:0])) && (i < 32'(addr_q[LB-1:0]) + xfer_bytes);
    end

    always_comb begin
        hready = !(state_q == WAIT || state_q == ERR1);
        hresp  = (state_q == ERR1 || state_q == ERR2);
        rdata  = '0;
        if (state_q == LAST && !write_q)
            for (int unsigned i = 0; i < NB; i++)
                if (lane_mask[i]) rdata[i*8 +: 8] = mem[base_addr | MAW'(i)];
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = rdata;

    // Memory is deliberately not reset; a reset in the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == LAST && write_q)
            for (int unsigned i = 0; i < NB; i++)
                if (lane_mask[i]) mem[base_addr | MAW'(i)] <= bus.HWDATA[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst)
            bytes_written <= '0;
        else if (state_q == LAST && write_q)
            bytes_written <= bytes_written + xfer_bytes;
    end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (0 and 2 wait states) driven through one pipelined
// AHB master, checked against a byte-array reference memory and a byte counter model.
module tb_ahb_mem_slave;
    localparam int MEM = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit          sel;
    logic        m_sel;
    logic [31:0] m_addr;
    logic [1:0]  m_trans;
    logic        m_write;
    logic [2:0]  m_size;
    logic [63:0] m_wdata;
    logic [31:0] bw0, bw2;

    ahb_mem_slave_if #(.AHB_ADDRESS_WIDTH(32), .AHB_DATA_WIDTH(64)) bus0 ();
    ahb_mem_slave_if #(.AHB_ADDRESS_WIDTH(32), .AHB_DATA_WIDTH(64)) bus2 ();

    assign bus0.HSEL   = m_sel && !sel;
    assign bus2.HSEL   = m_sel && sel;
    assign bus0.HADDR  = m_addr;   assign bus2.HADDR  = m_addr;
    assign bus0.HTRANS = m_trans;  assign bus2.HTRANS = m_trans;
    assign bus0.HWRITE = m_write;  assign bus2.HWRITE = m_write;
    assign bus0.HSIZE  = m_size;   assign bus2.HSIZE  = m_size;
    assign bus0.HWDATA = m_wdata;  assign bus2.HWDATA = m_wdata;

    ahb_mem_slave #(.AHB_ADDRESS_WIDTH(32), .AHB_DATA_WIDTH(64), .MEM_BYTES(MEM), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .bytes_written(bw0));
    ahb_mem_slave #(.AHB_ADDRESS_WIDTH(32), .AHB_DATA_WIDTH(64), .MEM_BYTES(MEM), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .bytes_written(bw2));

    logic        o_ready, o_resp;
    logic [63:0] o_rdata;
    logic [31:0] o_bw;
    assign o_ready = sel ? bus2.HREADY : bus0.HREADY;
    assign o_resp  = sel ? bus2.HRESP  : bus0.HRESP;
    assign o_rdata = sel ? bus2.HRDATA : bus0.HRDATA;
    assign o_bw    = sel ? bw2 : bw0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  ref_mem [2][MEM];
    logic [31:0] ref_bw  [2];

    // Transfer whose data phase is currently outstanding.
    bit          pend_v, pend_w, pend_ill;
    int unsigned pend_a, pend_s;
    logic [63:0] pend_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_illegal(input longint unsigned a, input int unsigned s);
        if (s > 3) return 1'b1;
        if (a % (64'd1 << s) != 0) return 1'b1;
        return (a + (64'd1 << s)) > MEM;
    endfunction

    function automatic logic [63:0] model_read(input bit d, input int unsigned a, input int unsigned s);
        logic [63:0] r;
        r = '0;
        for (int unsigned k = 0; k < (32'd1 << s); k++)
            r[((a % 8) + k) * 8 +: 8] = ref_mem[d][a + k];
        return r;
    endfunction

    // One bus step: completes the outstanding data phase (checking it) and presents a new address phase.
    task automatic step(input bit has_addr, input bit w, input int unsigned a, input int unsigned s,
                        input logic [63:0] d);
        int unsigned lows;
        int unsigned exp_lows;
        logic [63:0] exp_rd;
        lows = 0;
        chk("bytes_written", 64'(o_bw), 64'(ref_bw[sel]));
        m_wdata  = pend_v ? pend_d : 64'h0;
        exp_lows = !pend_v ? 0 : (pend_ill ? 1 : (sel ? 2 : 0));
        while (o_ready !== 1'b1 && lows < 20) begin
            chk("hresp_wait", 64'(o_resp), 64'(pend_v && pend_ill));
            chk("hrdata_wait", o_rdata, 64'h0);
            m_sel   = 1'($urandom);
            m_trans = 2'($urandom);
            m_addr  = $urandom;
            m_write = 1'($urandom);
            m_size  = 3'($urandom);
            lows++;
            @(posedge clk);
            @(negedge clk);
        end
        m_sel   = has_addr ? 1'b1 : 1'($urandom);
        m_trans = has_addr ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
        m_addr  = a;
        m_write = w;
        m_size  = 3'(s);
        chk("wait_cycles", 64'(lows), 64'(exp_lows));
        chk("hresp", 64'(o_resp), 64'(pend_v && pend_ill));
        exp_rd = '0;
        if (pend_v && !pend_ill && !pend_w) exp_rd = model_read(sel, pend_a, pend_s);
        chk("hrdata", o_rdata, exp_rd);
        if (pend_v && !pend_ill && pend_w) begin
            for (int unsigned k = 0; k < (32'd1 << pend_s); k++)
                ref_mem[sel][pend_a + k] = pend_d[((pend_a % 8) + k) * 8 +: 8];
            ref_bw[sel] = ref_bw[sel] + (32'd1 << pend_s);
        end
        pend_v   = has_addr;
        pend_w   = w;
        pend_a   = a;
        pend_s   = s;
        pend_d   = d;
        pend_ill = has_addr && model_illegal(a, s);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic random_steps(input int unsigned count);
        int unsigned a, s;
        for (int unsigned n = 0; n < count; n++) begin
            s = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       a = $urandom_range(0, 255);
                1:       a = MEM - $urandom_range(1, 16);
                2:       a = 32'h0001_0000 + $urandom_range(0, 255);
                default: a = $urandom_range(0, 255) & ~((32'd1 << (s > 3 ? 3 : s)) - 1);
            endcase
            step($urandom_range(0, 3) != 0, 1'($urandom), a, s, {$urandom, $urandom});
        end
        step(1'b0, 1'b0, 0, 0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < MEM; i++) begin
            ref_mem[0][i] = 8'h00;
            ref_mem[1][i] = 8'h00;
        end
        ref_bw[0] = '0;
        ref_bw[1] = '0;
        pend_v = 1'b0; pend_w = 1'b0; pend_ill = 1'b0; pend_a = 0; pend_s = 0; pend_d = '0;
        sel = 1'b0; m_sel = 1'b0; m_addr = '0; m_trans = 2'b00; m_write = 1'b0; m_size = '0; m_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hready0", 64'(bus0.HREADY), 64'd1);
        chk("rst_hresp0",  64'(bus0.HRESP),  64'd0);
        chk("rst_hrdata0", bus0.HRDATA,      64'h0);
        chk("rst_bw0",     64'(bw0),         64'd0);
        chk("rst_hready2", 64'(bus2.HREADY), 64'd1);
        chk("rst_bw2",     64'(bw2),         64'd0);
        rst = 1'b0;

        // Two wait-state instance: byte-lane placement, wait timing, back-to-back read
        sel = 1'b1;
        step(1'b1, 1'b1, 32'h13, 0, 64'h0000_0000_AB00_0000);
        step(1'b1, 1'b0, 32'h10, 3, '0);
        chk("byte_lane_read", o_rdata, 64'h0); // still in WAIT: bus returns zero
        step(1'b0, 1'b0, 0, 0, '0);
        random_steps(60);

        // Reset while a write to 0x20 sits in its wait states
        step(1'b1, 1'b1, 32'h20, 3, 64'h1122_3344_5566_7788);
        step(1'b1, 1'b1, 32'h20, 3, 64'hDEAD_BEEF_CAFE_F00D);
        rst = 1'b1;
        m_sel = 1'b0;
        m_trans = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hready", 64'(o_ready), 64'd1);
        chk("midrst_hresp",  64'(o_resp),  64'd0);
        chk("midrst_hrdata", o_rdata,      64'h0);
        chk("midrst_bw2",    64'(bw2),     64'd0);
        chk("midrst_bw0",    64'(bw0),     64'd0);
        rst = 1'b0;
        pend_v = 1'b0;
        ref_bw[0] = '0;
        ref_bw[1] = '0;
        step(1'b1, 1'b0, 32'h20, 3, '0);
        chk("midrst_mem", o_rdata, 64'h0);
        step(1'b0, 1'b0, 0, 0, '0);

        // Zero wait-state instance: write/read, misaligned and out-of-range errors
        sel = 1'b0;
        step(1'b1, 1'b1, 32'h10, 3, 64'h0807_0605_0403_0201);
        step(1'b1, 1'b0, 32'h10, 3, '0);
        step(1'b1, 1'b1, 32'h11, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr_rd_bw", 64'(o_bw), 64'd8);
        step(1'b1, 1'b0, MEM - 4, 3, '0);
        step(1'b1, 1'b0, 32'h10, 3, '0);
        step(1'b0, 1'b0, 0, 0, '0);
        chk("err_bw", 64'(o_bw), 64'd8);
        random_steps(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter AHB_ADDRESS_WIDTH, default 32, HADDR width (from ahb_pkg).
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 64, HWDATA/HRDATA width; DW/8 byte lanes.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, byte-addressable memory size.
REQ-004 SHALL have parameter WAIT_STATES, default 0, HREADY-low cycles inserted per OKAY transfer (0..15).
REQ-005 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port HSEL  in  1  slave select.
REQ-008 SHALL have port HADDR  in  AHB_ADDRESS_WIDTH  byte address, address phase.
REQ-009 SHALL have port HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3 (state_t).
REQ-010 SHALL have port HWRITE  in  1  1=write.
REQ-011 SHALL have port HSIZE  in  3  transfer size; 2**HSIZE bytes.
REQ-012 SHALL have port HWDATA  in  AHB_DATA_WIDTH  write data, data phase.
REQ-013 SHALL have port HREADY  out  1  transfer-done / bus-ready, fed back as the bus HREADY.
REQ-014 SHALL have port HRESP  out  1  0=OKAY, 1=ERROR.
REQ-015 SHALL have port HRDATA  out  AHB_DATA_WIDTH  read data.
REQ-016 SHALL have port bytes_written  out  32  count of committed write bytes.

Function
REQ-017 SHALL accept an address phase when HSEL=1, HTRANS is NONSEQ or SEQ, and HREADY=1 at the clock edge; it SHALL register HADDR, HSIZE, and HWRITE.
REQ-018 SHALL treat IDLE or BUSY, or HSEL=0, with HREADY=1 as a zero-wait OKAY with no access; the FSM SHALL go to or stay in IDLE.
REQ-019 SHALL implement FSM states IDLE, WAIT, LAST, ERR1, ERR2.
- Accepted legal transfer -> WAIT if WAIT_STATES>0, else LAST.
- WAIT: down-counter loaded with WAIT_STATES-1 at acceptance; -> LAST when the counter is 0.
- LAST: the data phase completes; a new accepted transfer follows the REQ-019 rules, else -> IDLE.
- Accepted illegal transfer -> ERR1 -> ERR2 -> IDLE/accept.
REQ-020 SHALL drive HREADY=0 in WAIT and ERR1, and HREADY=1 in IDLE, LAST and ERR2.
REQ-021 SHALL drive HRESP=1 in ERR1 and ERR2 only; WAIT_STATES SHALL NOT apply to errors.
REQ-022 SHALL classify a transfer as illegal if any of the following holds:
- HSIZE > log2(DW/8);
- HADDR mod 2**HSIZE != 0;
- HADDR + 2**HSIZE > MEM_BYTES.
REQ-023 SHALL, for a write in LAST, write lanes L..L+2**size-1 of HWDATA (L = addr mod DW/8) to mem[addr+k], k = 0..2**size-1, at the end of that cycle; other bytes SHALL be unchanged.
REQ-024 SHALL, for a read in LAST, drive HRDATA lanes L..L+2**size-1 from mem combinationally and all other lanes to 0; HRDATA SHALL be 0 in all other states.
REQ-025 SHALL sample the next address phase during the LAST or ERR2 cycle (pipelined); back-to-back transfers SHALL add no idle cycle.
REQ-026 SHALL return the newly written data for a read issued immediately after a write to the same address.
REQ-027 SHALL increment bytes_written by 2**size on each committed write; the count SHALL wrap modulo 2**32.
REQ-028 SHALL ignore HTRANS/HADDR changes while HREADY=0 (no acceptance).

Reset
REQ-029 SHALL, with rst=1, drive FSM=IDLE, counter=0, HREADY=1, HRESP=0, HRDATA=0, and bytes_written=0 at the next edge.
REQ-030 SHALL abort an in-progress transfer when reset is asserted mid-transfer; an uncommitted write SHALL NOT modify memory.
REQ-031 SHALL retain memory contents across reset; memory SHALL be initialised to 0 at time zero.

Verification
REQ-032 Write then read, WAIT_STATES=0: NONSEQ write HADDR=0x10, HSIZE=3, HWDATA=0x0807060504030201, then NONSEQ read 0x10 -> HREADY never low; the read returns 0x0807060504030201; bytes_written=8.
REQ-033 Byte write, lane placement: write HADDR=0x13, HSIZE=0, HWDATA byte lane 3=0xAB -> only mem[0x13]=0xAB; a read at 0x10, HSIZE=3 returns 0x00000000AB000000.
REQ-034 Wait states, WAIT_STATES=2: single write -> HREADY low for exactly 2 cycles, then high for 1; the next NONSEQ is accepted in the HREADY-high cycle.
REQ-035 Error response: write HADDR=0x11, HSIZE=1 (misaligned) -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; memory unchanged; bytes_written unchanged.
REQ-036 Out-of-range and reset: read HADDR=MEM_BYTES-4, HSIZE=3 -> ERROR; then rst asserted during the WAIT of a write to 0x20 -> mem[0x20..0x27] unchanged, outputs at reset values.
